// File: rtl/otter_wb_pkg.sv
// Shared types for the OTTER register-file writeback path.
package otter_wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MC
    } wb_sel_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; head is visible on dout whenever non-empty.
module wb_fifo
    import otter_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);
    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_q;

    assign dout  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and multicycle results into one registered register-file write per cycle,
// with a starvation guard for buffered results and a busy scoreboard for decode stalls.
module rf_writeback #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            mc_valid,
    output logic            mc_ready,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            rf_en,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic [31:0]     busy
);
    import otter_wb_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    wb_entry_t                    head;
    wb_entry_t                    mc_entry;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         has_head;
    logic                         alu_wr;
    logic                         starved;
    wb_sel_t                      sel;
    logic [CW-1:0]                starve_q;
    logic [CW-1:0]                starve_nxt;
    logic [31:0]                  busy_q;
    logic [31:0]                  busy_nxt;
    logic [4:0]                   wr_rd;
    logic [XLEN-1:0]              wr_data;
    logic                         rf_en_p1;
    logic [4:0]                   rf_wa_p1;
    logic [XLEN-1:0]              rf_wd_p1;

    assign mc_ready  = !fifo_full;
    assign mc_entry  = '{rd: mc_rd, data: mc_data};
    assign fifo_push = mc_valid && mc_ready && (mc_rd != '0);
    assign fifo_pop  = (sel == SEL_MC);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mc_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stage p0: pick one writer; a starved head outranks the ALU for one cycle.
    always_comb begin
        has_head   = !fifo_empty;
        alu_wr     = alu_valid && (alu_rd != '0);
        starved    = has_head && (starve_q == STARVE_MAX);
        sel        = SEL_NONE;
        starve_nxt = starve_q;
        alu_stall  = 1'b0;
        wr_rd      = head.rd;
        wr_data    = head.data;
        if (starved) begin
            sel        = SEL_MC;
            alu_stall  = 1'b1;
            starve_nxt = '0;
        end else if (alu_wr) begin
            sel     = SEL_ALU;
            wr_rd   = alu_rd;
            wr_data = alu_data;
            if ((fifo_count != '0) && (starve_q != STARVE_MAX)) begin
                starve_nxt = starve_q + 1'b1;
            end
        end else if (has_head) begin
            sel        = SEL_MC;
            starve_nxt = '0;
        end
    end

    // A new issue to the same register wins over the clear from a retiring entry.
    always_comb begin
        busy_nxt = busy_q;
        if (sel == SEL_MC) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Stage p1: registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_p1 <= 1'b0;
            rf_wa_p1 <= '0;
            rf_wd_p1 <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            rf_en_p1 <= (sel != SEL_NONE);
            if (sel != SEL_NONE) begin
                rf_wa_p1 <= wr_rd;
                rf_wd_p1 <= wr_data;
            end
            starve_q <= starve_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign rf_en = rf_en_p1;
    assign rf_wa = rf_wa_p1;
    assign rf_wd = rf_wd_p1;
    assign busy  = busy_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Randomised and directed bench for rf_writeback with a queue-based reference model and scoreboard.
module tb_rf_writeback;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        rf_en;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [36:0] mq[$];
    int          m_cnt = 0;
    logic [31:0] m_busy = '0;
    logic        last_stall = 1'b0;
    logic        last_acc = 1'b0;

    rf_writeback #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_rd     (mc_rd),
        .mc_data   (mc_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_en     (rf_en),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational handshakes, and advance the model.
    task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic iv, input logic [4:0] ird);
        exp_t        e;
        logic        starved;
        logic        acc;
        logic [36:0] hd;
        @(posedge clk);
        #2;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        mc_valid = mv; mc_rd = mrd; mc_data = md; iss_valid = iv; iss_rd = ird;
        #1;
        e = '0;
        if (r) begin
            mq.delete();
            m_cnt = 0;
            m_busy = '0;
            last_stall = 1'b0;
            last_acc = 1'b0;
        end else begin
            starved = (mq.size() > 0) && (m_cnt == LIMIT);
            check("alu_stall", {31'd0, alu_stall}, {31'd0, starved});
            check("mc_ready", {31'd0, mc_ready}, {31'd0, mq.size() < DEPTH});
            acc = mv && (mq.size() < DEPTH);
            if (starved) begin
                hd = mq.pop_front();
                e.en = 1'b1; e.wa = hd[36:32]; e.wd = hd[31:0];
                m_busy[hd[36:32]] = 1'b0;
                m_cnt = 0;
            end else if (av && ard != 5'd0) begin
                e.en = 1'b1; e.wa = ard; e.wd = ad;
                if (mq.size() > 0 && m_cnt < LIMIT) m_cnt++;
            end else if (mq.size() > 0) begin
                hd = mq.pop_front();
                e.en = 1'b1; e.wa = hd[36:32]; e.wd = hd[31:0];
                m_busy[hd[36:32]] = 1'b0;
                m_cnt = 0;
            end
            if (acc && mrd != 5'd0) mq.push_back({mrd, md});
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
            last_stall = starved;
            last_acc = acc;
        end
        e.busy = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every registered output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_en", {31'd0, rf_en}, {31'd0, e.en});
                if (e.en) begin
                    check("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                    check("rf_wd", rf_wd, e.wd);
                end
                check("busy", busy, e.busy);
            end
        end
    end

    initial begin
        logic [4:0]  ard;
        logic        r_av, r_mv, r_iv, r_rst;
        logic [4:0]  r_ard, r_mrd, r_ird;
        logic [31:0] r_ad, r_md;
        int          idx;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // ALU only, then rd=0 produces nothing
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 32'h11112222, 0, 0, 0, 0, 0);
        idle(2);

        // Scoreboard round trip for x7
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(2);
        step(0, 0, 0, 0, 1, 7, 32'h12, 0, 0);
        idle(3);

        // Starvation: one entry for x9 behind a stream of ALU writes
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        ard = 5'd1;
        step(0, 1, ard, 32'hA0 + ard, 1, 9, 32'h99, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (!last_stall) ard = ard + 5'd1;
            step(0, 1, ard, 32'hA0 + ard, 0, 0, 0, 0, 0);
        end
        idle(2);

        // Backpressure: ALU busy, three back-to-back offers
        idx = 0;
        ard = 5'd10;
        for (int i = 0; i < 12; i++) begin
            ard = (ard == 5'd20) ? 5'd10 : ard + 5'd1;
            if (idx < 3) begin
                step(0, 1, ard, 32'hB0 + ard, 1, 5'(21 + idx), 32'hC0 + idx, 0, 0);
                if (last_acc) idx++;
            end else begin
                step(0, 1, ard, 32'hB0 + ard, 0, 0, 0, 0, 0);
            end
        end
        idle(4);

        // Simultaneous set and clear of x3
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 1, 3, 32'h33, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        idle(2);
        check("busy3_sticky", {31'd0, busy[3]}, 32'd1);
        step(0, 0, 0, 0, 1, 3, 32'h34, 0, 0);
        idle(3);

        // Reset with two buffered entries and busy = 0x88
        step(0, 1, 1, 32'h1, 0, 0, 0, 1, 3);
        step(0, 1, 2, 32'h2, 1, 3, 32'h303, 1, 7);
        step(0, 1, 4, 32'h4, 1, 7, 32'h707, 0, 0);
        step(0, 1, 5, 32'h5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Randomised traffic with hold-while-stalled upstream behaviour
        r_av = 0; r_ard = 0; r_ad = 0; r_mv = 0; r_mrd = 0; r_md = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(last_stall && r_av)) begin
                r_av  = ($urandom_range(0, 99) < 65);
                r_ard = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 7) == 0) r_ard = 5'd0;
                r_ad  = $urandom;
            end
            if (!(r_mv && !last_acc)) begin
                r_mv  = ($urandom_range(0, 99) < 45);
                r_mrd = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) r_mrd = 5'd0;
                r_md  = $urandom;
            end
            r_iv  = ($urandom_range(0, 99) < 30);
            r_ird = 5'($urandom_range(0, 31));
            r_rst = ($urandom_range(0, 149) == 0);
            step(r_rst, r_av, r_ard, r_ad, r_mv, r_mrd, r_md, r_iv, r_ird);
        end
        idle(6);

        @(posedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Producer side of the register file's single write port (wd/en/wa).
- Merges writes from the single-cycle ALU path and a multicycle path (loads, mul/div) into one registered write per cycle.
- Keeps a per-register busy scoreboard for decode-stage hazard stalls.
- Sits between the execute/memory stages and the register file in the OTTER MCU.

Parameters:
XLEN, 32, data width of write values
FIFO_DEPTH, 2, multicycle result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles a buffered multicycle result may wait before taking priority over the ALU

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_stall  out  1  ALU write not accepted this cycle; upstream holds alu_* stable
mc_valid  in  1  multicycle result offered
mc_ready  out  1  multicycle result accepted when mc_valid && mc_ready
mc_rd  in  5  multicycle destination register
mc_data  in  XLEN  multicycle result
iss_valid  in  1  multicycle op issued this cycle
iss_rd  in  5  destination of issued multicycle op
rf_en  out  1  register file write enable (drives en)
rf_wa  out  5  register file write address (drives wa)
rf_wd  out  XLEN  register file write data (drives wd)
busy  out  32  bit i set = register i awaiting a multicycle result

Behaviour:
- Reset: rf_en=0, rf_wa=0, rf_wd=0, busy=0, FIFO empty, starve counter=0, alu_stall=0. Mid-operation reset discards buffered entries and clears busy. No write is issued in the cycle after reset.
- rf_en/rf_wa/rf_wd are registered. A selected write appears on the outputs exactly 1 cycle after selection. rf_en is high for one cycle per write.
- mc_ready = !fifo_full, from registered state only, with no combinational path from mc_valid.
  - Accepted entries with mc_rd=0 are dropped: not enqueued, no busy change.
- Cut-through: an accepted mc entry is still written to the FIFO. The head is available for selection one cycle after acceptance. Minimum latency from mc accept to rf_en is 2 cycles.
- Selection each cycle, highest priority first:
  1. Starved: FIFO non-empty and starve counter = STARVE_LIMIT. Pop the head, alu_stall=1 (combinational), counter reset to 0.
  2. alu_valid && alu_rd!=0. Issue the ALU write, alu_stall=0. If the FIFO is non-empty, the counter increments, saturating at STARVE_LIMIT.
  3. FIFO non-empty. Pop the head, counter reset to 0.
  4. Otherwise no write next cycle.
- alu_valid with alu_rd=0 is accepted (alu_stall=0) and produces no write. It does not count as ALU occupancy for starvation.
- FIFO order is strict: pop order equals acceptance order. Push and pop in the same cycle are legal when full: mc_ready stays 0 that cycle, and the freed slot is visible next cycle.
- Busy scoreboard:
  - Set: iss_valid && iss_rd!=0 sets busy[iss_rd].
  - Clear: a popped FIFO entry clears busy[rd] on the same edge its write is registered into rf_*.
  - Same register set and cleared in the same cycle: the bit ends at 1.
  - ALU writes never touch busy.
  - busy[0] is always 0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count so full and empty are distinguished.

Decomposition:
- Package otter_wb_pkg:
  - XLEN and REG_ADDR_W=5 constants.
  - wb_entry_t packed struct {rd[4:0], data[XLEN-1:0]}.
  - wb_sel_t enum {SEL_NONE, SEL_ALU, SEL_MC}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count and synchronous active-high rst.
- Arbitration, starvation counter and scoreboard stay in rf_writeback.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle rf_en=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle rf_en=0. Repeat with rd=0 -> rf_en stays 0.
- Scoreboard round trip: iss rd=7 at cycle 0 -> busy[7]=1 at cycle 1. mc accept rd=7, data=0x12 at cycle 3, ALU idle -> rf_en/wa=7/wd=0x12 at cycle 5, and busy[7]=0 at cycle 5.
- Starvation: FIFO holds one entry rd=9, ALU writes distinct rds every cycle -> STARVE_LIMIT=4 ALU writes, then alu_stall=1 for exactly one cycle and rd=9 is written. The held ALU write follows the next cycle with no loss.
- Backpressure: ALU busy and 3 back-to-back mc offers with FIFO_DEPTH=2 -> mc_ready=0 after 2 accepts. The third is accepted only after the first pop, and writes occur in acceptance order.
- Simultaneous set/clear: iss rd=3 in the same cycle a popped entry for rd=3 is registered -> busy[3]=1 afterwards.
- Reset mid-operation: 2 FIFO entries and busy=0x0000_0088, assert rst for 1 cycle -> rf_en=0 and busy=0 the next cycle, mc_ready=1, and no stale writes are ever issued.
